inst_encoder: RTL and testbench

//  Encoder counterpart of the control decoder: packs instruction fields into 32-bit

---
 rtl/inst_encoder_pkg.sv | 83 ++++++++
 rtl/enc_fifo2.sv | 71 +++++++
 rtl/inst_encoder.sv | 133 +++++++++++++
 tb/tb_inst_encoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared ISA definitions: instruction kinds, MIPS opcode/funct constants and field packers.
package inst_encoder_pkg;

  localparam int unsigned KIND_W  = 5;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned TGT_W   = 26;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned WORD_W  = 32;

  typedef enum logic [KIND_W-1:0] {
    ENC_ADD   = 5'd0,
    ENC_ADDU  = 5'd1,
    ENC_SUBU  = 5'd2,
    ENC_AND   = 5'd3,
    ENC_OR    = 5'd4,
    ENC_SLT   = 5'd5,
    ENC_SLL   = 5'd6,
    ENC_JR    = 5'd7,
    ENC_ADDI  = 5'd8,
    ENC_ADDIU = 5'd9,
    ENC_ANDI  = 5'd10,
    ENC_ORI   = 5'd11,
    ENC_LW    = 5'd12,
    ENC_SW    = 5'd13,
    ENC_BEQ   = 5'd14,
    ENC_LUI   = 5'd15,
    ENC_J     = 5'd16,
    ENC_JAL   = 5'd17
  } enc_kind_e;

  localparam logic [OP_W-1:0] OPCODE_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OPCODE_J     = 6'h02;
  localparam logic [OP_W-1:0] OPCODE_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OPCODE_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OPCODE_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OPCODE_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OPCODE_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OPCODE_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OPCODE_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OPCODE_LW    = 6'h23;
  localparam logic [OP_W-1:0] OPCODE_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FUNCT_SLL  = 6'h00;
  localparam logic [FUNCT_W-1:0] FUNCT_JR   = 6'h08;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] FUNCT_SUBU = 6'h23;
  localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 6'h2A;

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] shamt;
    logic [IMM_W-1:0] imm;
    logic [TGT_W-1:0] target;
  } enc_fields_t;

  function automatic logic [WORD_W-1:0] pack_r(input logic [REG_W-1:0] rs,
                                               input logic [REG_W-1:0] rt,
                                               input logic [REG_W-1:0] rd,
                                               input logic [REG_W-1:0] shamt,
                                               input logic [FUNCT_W-1:0] funct);
    return {OPCODE_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [WORD_W-1:0] pack_i(input logic [OP_W-1:0] op,
                                               input logic [REG_W-1:0] rs,
                                               input logic [REG_W-1:0] rt,
                                               input logic [IMM_W-1:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [WORD_W-1:0] pack_j(input logic [OP_W-1:0] op,
                                               input logic [TGT_W-1:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry FIFO with registered valid/ready flags; clear flushes occupancy but keeps data.
module enc_fifo2 #(
  parameter int unsigned DATA_W = 42
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_ready
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_cnt;
  logic              r_valid;
  logic              r_ready;
  logic              w_pop;
  logic              w_push;
  logic [1:0]        w_cnt_nxt;

  assign w_pop  = i_pop & r_valid;
  assign w_push = i_push & ((r_cnt != 2'd2) | w_pop);

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b1;
    end else if (i_clear) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != 2'd0);
      r_ready <= (w_cnt_nxt != 2'd2);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = r_valid;
  assign o_ready = r_ready;

endmodule

// File: rtl/inst_encoder.sv
// Packs instruction fields into 32-bit MIPS words and streams them, address-stamped, to IMEM.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [KIND_W-1:0] in_kind,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_shamt,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [TGT_W-1:0]  in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned ENTRY_W = WORD_W + ADDR_W;
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST    = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(1) << ADDR_W;

  enc_fields_t       w_f;
  logic [WORD_W-1:0] w_word;
  logic              w_legal;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [ENTRY_W-1:0] w_head;
  logic              w_fifo_valid;
  logic              w_fifo_ready;

  logic [ADDR_W-1:0] r_tail;
  logic              r_full;
  logic              r_err;
  logic [CNT_W-1:0]  r_word_cnt;

  assign w_f = '{rs: in_rs, rt: in_rt, rd: in_rd, shamt: in_shamt,
                 imm: in_imm, target: in_target};

  // Field packing per kind; unused fields are forced to zero
  always_comb begin
    w_word  = '0;
    w_legal = 1'b1;
    case (enc_kind_e'(in_kind))
      ENC_ADD:   w_word = pack_r(w_f.rs, w_f.rt, w_f.rd, 5'd0, FUNCT_ADD);
      ENC_ADDU:  w_word = pack_r(w_f.rs, w_f.rt, w_f.rd, 5'd0, FUNCT_ADDU);
      ENC_SUBU:  w_word = pack_r(w_f.rs, w_f.rt, w_f.rd, 5'd0, FUNCT_SUBU);
      ENC_AND:   w_word = pack_r(w_f.rs, w_f.rt, w_f.rd, 5'd0, FUNCT_AND);
      ENC_OR:    w_word = pack_r(w_f.rs, w_f.rt, w_f.rd, 5'd0, FUNCT_OR);
      ENC_SLT:   w_word = pack_r(w_f.rs, w_f.rt, w_f.rd, 5'd0, FUNCT_SLT);
      ENC_SLL:   w_word = pack_r(5'd0, w_f.rt, w_f.rd, w_f.shamt, FUNCT_SLL);
      ENC_JR:    w_word = pack_r(w_f.rs, 5'd0, 5'd0, 5'd0, FUNCT_JR);
      ENC_ADDI:  w_word = pack_i(OPCODE_ADDI, w_f.rs, w_f.rt, w_f.imm);
      ENC_ADDIU: w_word = pack_i(OPCODE_ADDIU, w_f.rs, w_f.rt, w_f.imm);
      ENC_ANDI:  w_word = pack_i(OPCODE_ANDI, w_f.rs, w_f.rt, w_f.imm);
      ENC_ORI:   w_word = pack_i(OPCODE_ORI, w_f.rs, w_f.rt, w_f.imm);
      ENC_LW:    w_word = pack_i(OPCODE_LW, w_f.rs, w_f.rt, w_f.imm);
      ENC_SW:    w_word = pack_i(OPCODE_SW, w_f.rs, w_f.rt, w_f.imm);
      ENC_BEQ:   w_word = pack_i(OPCODE_BEQ, w_f.rs, w_f.rt, w_f.imm);
      ENC_LUI:   w_word = pack_i(OPCODE_LUI, 5'd0, w_f.rt, w_f.imm);
      ENC_J:     w_word = pack_j(OPCODE_J, w_f.target);
      ENC_JAL:   w_word = pack_j(OPCODE_JAL, w_f.target);
      default:   w_legal = 1'b0;
    endcase
  end

  assign in_ready = w_fifo_ready & ~r_full;
  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & w_legal & ~clear;
  assign w_pop    = w_fifo_valid & out_ready;

  enc_fifo2 #(.DATA_W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (clear),
    .i_push  (w_push),
    .i_data  ({w_word, r_tail}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_fifo_valid),
    .o_ready (w_fifo_ready)
  );

  // Tail address advances per push; full latches once the last address is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tail     <= BASE;
      r_full     <= 1'b0;
      r_err      <= 1'b0;
      r_word_cnt <= '0;
    end else if (clear) begin
      r_tail     <= BASE;
      r_full     <= 1'b0;
      r_err      <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + ADDR_W'(1);
        if (r_tail == LAST) begin
          r_full <= 1'b1;
        end
      end
      if (w_accept && !w_legal) begin
        r_err <= 1'b1;
      end
      if (w_pop && (r_word_cnt != CNT_MAX)) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
    end
  end

  // When empty, show the address the next word will take
  assign out_valid = w_fifo_valid;
  assign out_word  = w_head[ENTRY_W-1:ADDR_W];
  assign out_addr  = w_fifo_valid ? w_head[ADDR_W-1:0] : r_tail;
  assign full      = r_full;
  assign err       = r_err;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encodings, back-pressure, illegal kinds, address exhaustion, reset.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [9:0]  out_addr;
  logic        full;
  logic        err;
  logic [10:0] word_cnt;

  logic        s_clear;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [15:0] s_in_imm;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [31:0] s_out_word;
  logic [1:0]  s_out_addr;
  logic        s_full;
  logic        s_err;
  logic [2:0]  s_word_cnt;

  int n_checks;
  int n_errors;
  int acc;

  typedef struct {
    logic [4:0]  kind;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [11];

  inst_encoder #(.ADDR_W(10), .BASE_ADDR(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .full(full), .err(err), .word_cnt(word_cnt)
  );

  inst_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
    .clk(clk), .rst_n(rst_n), .clear(s_clear),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_kind(5'(ENC_ADDIU)),
    .in_rs(5'd0), .in_rt(5'd8), .in_rd(5'd0), .in_shamt(5'd0),
    .in_imm(s_in_imm), .in_target(26'd0),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_word(s_out_word),
    .out_addr(s_out_addr), .full(s_full), .err(s_err), .word_cnt(s_word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tgt);
    in_kind   = k;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_shamt  = sh;
    in_imm    = imm;
    in_target = tgt;
    in_valid  = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    tbl[0]  = '{5'(ENC_ADD),  5'd1,  5'd2,  5'd3, 5'd7, 16'h0000, 26'h0,       32'h00221820};
    tbl[1]  = '{5'(ENC_SLL),  5'd7,  5'd3,  5'd2, 5'd4, 16'h0000, 26'h0,       32'h00031100};
    tbl[2]  = '{5'(ENC_LW),   5'd29, 5'd9,  5'd0, 5'd0, 16'h0004, 26'h0,       32'h8FA90004};
    tbl[3]  = '{5'(ENC_J),    5'd0,  5'd0,  5'd0, 5'd0, 16'h0000, 26'h0100000, 32'h08100000};
    tbl[4]  = '{5'(ENC_JR),   5'd31, 5'd5,  5'd6, 5'd1, 16'h0000, 26'h0,       32'h03E00008};
    tbl[5]  = '{5'(ENC_LUI),  5'd5,  5'd1,  5'd0, 5'd0, 16'h1234, 26'h0,       32'h3C011234};
    tbl[6]  = '{5'(ENC_SW),   5'd29, 5'd31, 5'd0, 5'd0, 16'hFFFC, 26'h0,       32'hAFBFFFFC};
    tbl[7]  = '{5'(ENC_BEQ),  5'd1,  5'd2,  5'd0, 5'd0, 16'hFFFF, 26'h0,       32'h1022FFFF};
    tbl[8]  = '{5'(ENC_JAL),  5'd0,  5'd0,  5'd0, 5'd0, 16'h0000, 26'h0000040, 32'h0C000040};
    tbl[9]  = '{5'(ENC_SUBU), 5'd4,  5'd5,  5'd6, 5'd0, 16'h0000, 26'h0,       32'h00853023};
    tbl[10] = '{5'(ENC_ORI),  5'd2,  5'd3,  5'd0, 5'd0, 16'h00FF, 26'h0,       32'h344300FF};

    rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0;
    set_in(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    in_valid = 1'b0;
    s_clear = 1'b0; s_in_valid = 1'b0; s_in_imm = 16'h0; s_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_word", 64'(out_word), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd16);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_word_cnt", 64'(word_cnt), 64'd0);
    rst_n = 1'b1;
    cyc();

    // single ADDIU, one-cycle latency
    out_ready = 1'b1;
    set_in(5'(ENC_ADDIU), 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0);
    cyc();
    chk("addiu_valid", 64'(out_valid), 64'd1);
    chk("addiu_word", 64'(out_word), 64'h24080005);
    chk("addiu_addr", 64'(out_addr), 64'd16);
    in_valid = 1'b0;
    cyc();
    chk("addiu_drained", 64'(out_valid), 64'd0);
    chk("addiu_cnt", 64'(word_cnt), 64'd1);

    // back-to-back stream at full throughput
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].kind, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].sh, tbl[i].imm, tbl[i].tgt);
      cyc();
      chk("stream_word", 64'(out_word), 64'(tbl[i].exp));
      chk("stream_addr", 64'(out_addr), 64'(17 + i));
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_cnt", 64'(word_cnt), 64'd12);
    chk("stream_empty", 64'(out_valid), 64'd0);

    // back-pressure: only two accepts, head held stable
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      set_in(5'(ENC_ADDIU), 5'd0, 5'd8, 5'd0, 5'd0, 16'h0010 + 16'(i), 26'h0);
      if (in_ready) acc++;
      cyc();
      if (i > 0) chk("bp_word_stable", 64'(out_word), 64'h24080010);
    end
    chk("bp_accepts", 64'(acc), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_addr", 64'(out_addr), 64'd28);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("bp_drain_word", 64'(out_word), 64'h24080011);
    chk("bp_drain_addr", 64'(out_addr), 64'd29);
    cyc();
    chk("bp_drain_empty", 64'(out_valid), 64'd0);
    chk("bp_cnt", 64'(word_cnt), 64'd14);
    chk("bp_ready_back", 64'(in_ready), 64'd1);

    // illegal kind between two ADDIUs
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_cnt", 64'(word_cnt), 64'd0);
    chk("clr_addr", 64'(out_addr), 64'd16);
    set_in(5'(ENC_ADDIU), 5'd0, 5'd8, 5'd0, 5'd0, 16'h0021, 26'h0);
    cyc();
    chk("ill_first_word", 64'(out_word), 64'h24080021);
    chk("ill_first_addr", 64'(out_addr), 64'd16);
    set_in(5'h1F, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    cyc();
    chk("ill_dropped", 64'(out_valid), 64'd0);
    chk("ill_err", 64'(err), 64'd1);
    set_in(5'(ENC_ADDIU), 5'd0, 5'd8, 5'd0, 5'd0, 16'h0022, 26'h0);
    cyc();
    chk("ill_second_word", 64'(out_word), 64'h24080022);
    chk("ill_second_addr", 64'(out_addr), 64'd17);
    in_valid = 1'b0;
    cyc();
    chk("ill_cnt", 64'(word_cnt), 64'd2);
    chk("ill_err_sticky", 64'(err), 64'd1);

    // address exhaustion on the 4-word instance
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      s_in_imm = 16'h0040 + 16'(i);
      if (s_in_ready) acc++;
      cyc();
      if (i == 3) begin
        chk("sm_full_set", 64'(s_full), 64'd1);
        chk("sm_ready_low", 64'(s_in_ready), 64'd0);
        chk("sm_last_addr", 64'(s_out_addr), 64'd3);
        chk("sm_last_word", 64'(s_out_word), 64'h24080043);
      end
    end
    chk("sm_accepts", 64'(acc), 64'd4);
    chk("sm_empty", 64'(s_out_valid), 64'd0);
    chk("sm_full_held", 64'(s_full), 64'd1);
    chk("sm_cnt", 64'(s_word_cnt), 64'd4);
    chk("sm_err", 64'(s_err), 64'd0);
    s_in_valid = 1'b0;
    s_clear = 1'b1;
    cyc();
    s_clear = 1'b0;
    chk("sm_clr_full", 64'(s_full), 64'd0);
    chk("sm_clr_addr", 64'(s_out_addr), 64'd0);
    chk("sm_clr_ready", 64'(s_in_ready), 64'd1);
    chk("sm_clr_cnt", 64'(s_word_cnt), 64'd0);

    // asynchronous reset mid-burst
    out_ready = 1'b0;
    set_in(5'(ENC_ADDIU), 5'd0, 5'd8, 5'd0, 5'd0, 16'h0031, 26'h0);
    cyc();
    in_imm = 16'h0032;
    cyc();
    in_valid = 1'b0;
    chk("mid_valid_pre", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", 64'(out_valid), 64'd0);
    chk("mid_ready", 64'(in_ready), 64'd1);
    chk("mid_addr", 64'(out_addr), 64'd16);
    chk("mid_word", 64'(out_word), 64'd0);
    chk("mid_err", 64'(err), 64'd0);
    chk("mid_cnt", 64'(word_cnt), 64'd0);
    #2;
    rst_n = 1'b1;
    cyc();
    out_ready = 1'b1;
    set_in(5'(ENC_ADDIU), 5'd0, 5'd8, 5'd0, 5'd0, 16'h0033, 26'h0);
    cyc();
    chk("post_rst_word", 64'(out_word), 64'h24080033);
    chk("post_rst_addr", 64'(out_addr), 64'd16);
    in_valid = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
